// File: rtl/wavelet_accelerator_packet_serializer.sv
// Word FIFO feeding a packet serializer: INPUT_WIDTH-bit words in, PACKET_WIDTH-bit packets out.
// Optional build macro WAVELET_SERIALIZER_MSB_FIRST_EN emits packets most-significant first.
module wavelet_accelerator_packet_serializer #(
   parameter int unsigned INPUT_WIDTH  = 32,
   parameter int unsigned PACKET_WIDTH = 8,
   parameter int unsigned DEPTH        = 2,
   localparam int unsigned N  = INPUT_WIDTH / PACKET_WIDTH,
   localparam int unsigned OW = $clog2(N),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [INPUT_WIDTH-1:0]  data_in,
   input  logic [OW-1:0]           in_offset,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [PACKET_WIDTH-1:0] data_out,
   output logic                    out_last,
   output logic [CW-1:0]           word_count,
   output logic                    busy
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                  state;
   logic [INPUT_WIDTH-1:0]  word_mem [DEPTH];
   logic [OW-1:0]           off_mem  [DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [OW-1:0]           cnt;

   logic                    empty;
   logic                    full;
   logic                    push;
   logic                    xfer;
   logic                    pop;
   logic [OW-1:0]           pkt_idx;
   logic [OW-1:0]           slice;
   logic [INPUT_WIDTH-1:0]  head_word;
   logic [PACKET_WIDTH-1:0] packets [N];

   // Handshake and packet selection, all derived from registered state
   always_comb begin
      empty     = (word_count == '0);
      full      = (word_count == CW'(DEPTH));
      in_ready  = !full;
      out_valid = !empty;
      busy      = !empty;
      push      = in_valid && !full;
      head_word = word_mem[rd_ptr];
      pkt_idx   = off_mem[rd_ptr] + cnt;
`ifdef WAVELET_SERIALIZER_MSB_FIRST_EN
      slice     = OW'(N - 1) - pkt_idx;
`else
      slice     = pkt_idx;
`endif
      for (int i = 0; i < int'(N); i++) begin
         packets[i] = head_word[i*PACKET_WIDTH +: PACKET_WIDTH];
      end
      out_last  = !empty && (pkt_idx == OW'(N - 1));
      xfer      = !empty && out_ready;
      pop       = xfer && out_last;
      data_out  = empty ? '0 : packets[slice];
   end

   // Storage array carries no reset; empty/full masking hides stale entries
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         word_mem[wr_ptr] <= data_in;
         off_mem[wr_ptr]  <= in_offset;
      end
   end

   // Pointers, occupancy, packet counter and state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         word_count <= '0;
      end else if (flush) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         word_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (xfer) begin
            if (out_last) begin
               rd_ptr <= rd_ptr + AW'(1);
               cnt    <= '0;
            end else begin
               cnt    <= cnt + OW'(1);
            end
         end
         case ({push, pop})
            2'b10:   word_count <= word_count + CW'(1);
            2'b01:   word_count <= word_count - CW'(1);
            default: word_count <= word_count;
         endcase
         case (state)
            IDLE:    if (push) state <= STREAM;
            STREAM:  if (pop && !push && word_count == CW'(1)) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wavelet_accelerator_packet_serializer.sv
// Scoreboard bench for the packet serializer: stimulus queues expected packets, a monitor checks transfers.
module tb_wavelet_accelerator_packet_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_in;
   logic [1:0]  in_offset;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  data_out;
   logic        out_last;
   logic [1:0]  word_count;
   logic        busy;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   waits;

   wavelet_accelerator_packet_serializer #(
      .INPUT_WIDTH(32), .PACKET_WIDTH(8), .DEPTH(2)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .in_offset(in_offset),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .out_last(out_last),
      .word_count(word_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Queue one expected packet; both orderings are hand-computed
   task automatic ep(input logic [7:0] lsb_v, input logic [7:0] msb_v, input logic last);
`ifdef WAVELET_SERIALIZER_MSB_FIRST_EN
      sb.push_back('{msb_v, last});
`else
      sb.push_back('{lsb_v, last});
`endif
   endtask

   // Called #1 after a rising edge; returns #1 after the accepting edge
   task automatic push(input logic [31:0] w, input logic [1:0] off, output int nw);
      logic ok;
      ok        = 1'b0;
      nw        = 0;
      data_in   = w;
      in_offset = off;
      in_valid  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) break;
         nw++;
      end
      in_valid = 1'b0;
      if (!ok) chk("push_timeout", 32'(ok), 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk("drain_left", 32'(sb.size()), 0);
   endtask

   // Monitor: every transfer must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pkt: got %0h, required none (t=%0t)", data_out, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("pkt_data", 32'(data_out), 32'(mon_e.d));
            chk("pkt_last", 32'(out_last), 32'(mon_e.l));
         end
      end
   end

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; data_in = '0; in_offset = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_data_out", 32'(data_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_word_count", 32'(word_count), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single word, offset 0, free-running output
      out_ready = 1'b1;
      ep(8'hAA, 8'hDD, 1'b0); ep(8'hBB, 8'hCC, 1'b0); ep(8'hCC, 8'hBB, 1'b0); ep(8'hDD, 8'hAA, 1'b1);
      push(32'hDDCCBBAA, 2'd0, waits);
      chk("t1_busy_after_push", 32'(busy), 1);
      chk("t1_wc_after_push", 32'(word_count), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("t1_busy_before_last", 32'(busy), 1);
      @(posedge clk);
      #1;
      chk("t1_busy_after_last", 32'(busy), 0);
      drain();

      // Offsets 2 and 3, word_count sequence 1,2,2,1,0
      out_ready = 1'b0;
      ep(8'h33, 8'h22, 1'b0); ep(8'h44, 8'h11, 1'b1); ep(8'h88, 8'h55, 1'b1);
      push(32'h44332211, 2'd2, waits);
      chk("t2_wc1", 32'(word_count), 1);
      push(32'h88776655, 2'd3, waits);
      chk("t2_wc2", 32'(word_count), 2);
      chk("t2_in_ready_full", 32'(in_ready), 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("t2_wc_mid", 32'(word_count), 2);
      @(posedge clk); #1;
      chk("t2_wc_pop1", 32'(word_count), 1);
      @(posedge clk); #1;
      chk("t2_wc_pop2", 32'(word_count), 0);
      drain();

      // Back-pressure: third word held upstream until the first pop frees a slot
      out_ready = 1'b0;
      ep(8'h00, 8'h03, 1'b0); ep(8'h01, 8'h02, 1'b0); ep(8'h02, 8'h01, 1'b0); ep(8'h03, 8'h00, 1'b1);
      push(32'h03020100, 2'd0, waits);
      ep(8'h04, 8'h07, 1'b0); ep(8'h05, 8'h06, 1'b0); ep(8'h06, 8'h05, 1'b0); ep(8'h07, 8'h04, 1'b1);
      push(32'h07060504, 2'd0, waits);
      ep(8'h08, 8'h0B, 1'b0); ep(8'h09, 8'h0A, 1'b0); ep(8'h0A, 8'h09, 1'b0); ep(8'h0B, 8'h08, 1'b1);
      fork
         push(32'h0B0A0908, 2'd0, waits);
         begin
            repeat (3) @(posedge clk);
            #1;
            chk("t3_in_ready_full", 32'(in_ready), 0);
            chk("t3_wc_full", 32'(word_count), 2);
            chk("t3_out_valid_stall", 32'(out_valid), 1);
            chk("t3_data_stall", 32'(data_out), 32'(sb[0].d));
            out_ready = 1'b1;
         end
      join
      chk("t3_accept_delay", 32'(waits), 7);
      chk("t3_wc_after_accept", 32'(word_count), 2);
      drain();

      // Full FIFO: last-packet pop coincides with in_valid; push lands one cycle later
      out_ready = 1'b0;
      ep(8'hA1, 8'hD4, 1'b1);
      push(32'hA1B2C3D4, 2'd3, waits);
      ep(8'hE5, 8'h18, 1'b1);
      push(32'hE5F60718, 2'd3, waits);
      chk("t4_out_last_single", 32'(out_last), 1);
      out_ready = 1'b1;
      ep(8'h38, 8'h47, 1'b0); ep(8'h29, 8'h56, 1'b1);
      push(32'h29384756, 2'd2, waits);
      chk("t4_accept_delay", 32'(waits), 1);
      chk("t4_wc", 32'(word_count), 1);
      drain();
      chk("t4_busy_idle", 32'(busy), 0);

      // Flush mid-word with a competing push
      out_ready = 1'b1;
      ep(8'h0C, 8'h0F, 1'b0); ep(8'h0D, 8'h0E, 1'b0); ep(8'h0E, 8'h0D, 1'b0); ep(8'h0F, 8'h0C, 1'b1);
      push(32'h0F0E0D0C, 2'd0, waits);
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1; in_valid = 1'b1; data_in = 32'hBADBADBA; in_offset = 2'd0;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("t5_out_valid", 32'(out_valid), 0);
      chk("t5_wc", 32'(word_count), 0);
      chk("t5_in_ready", 32'(in_ready), 1);
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("t5_stays_empty", 32'(out_valid), 0);

      // Asynchronous reset mid-word, then a fresh word
      out_ready = 1'b0;
      push(32'h11223344, 2'd0, waits);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_out_valid", 32'(out_valid), 0);
      chk("t6_rst_wc", 32'(word_count), 0);
      chk("t6_rst_in_ready", 32'(in_ready), 1);
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t6_no_pkt_after_rst", 32'(out_valid), 0);
      ep(8'h0D, 8'h0A, 1'b0); ep(8'h0C, 8'h0B, 1'b0); ep(8'h0B, 8'h0C, 1'b0); ep(8'h0A, 8'h0D, 1'b1);
      push(32'h0A0B0C0D, 2'd0, waits);
`ifdef WAVELET_SERIALIZER_MSB_FIRST_EN
      chk("t6_first_pkt", 32'(data_out), 32'h0A);
`else
      chk("t6_first_pkt", 32'(data_out), 32'h0D);
`endif
      drain();
      chk("t6_busy_idle", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wavelet_accelerator_packet_serializer.md
Name: wavelet_accelerator_packet_serializer

Overview:
- Parametrised successor to the accelerator's word-to-packet deployer.
- Accepts INPUT_WIDTH-bit words through a valid/ready input port and buffers them in a DEPTH-entry word FIFO.
- Emits each word as a stream of PACKET_WIDTH-bit packets through a valid/ready output port, starting at a per-word packet offset.
- Sits between the accelerator's memory read path and the packet-wide wavelet datapath; replaces tri-state output muxing with a proper handshake and back-pressure.

Parameters:
INPUT_WIDTH, 32, word width in bits; must be an integer multiple of PACKET_WIDTH.
PACKET_WIDTH, 8, output packet width in bits.
DEPTH, 2, word FIFO entries; power of two, >= 2.
Derived (localparam): N = INPUT_WIDTH/PACKET_WIDTH (power of two, >= 2); OW = clog2(N); CW = clog2(DEPTH+1).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of FIFO and packet counter
in_valid  input  1  data_in/in_offset valid
in_ready  output  1  FIFO can accept a word
data_in  input  INPUT_WIDTH  word to serialize
in_offset  input  OW  index of the first packet to emit from this word
out_valid  output  1  data_out valid
out_ready  input  1  downstream accepts packet
data_out  output  PACKET_WIDTH  current packet
out_last  output  1  current packet is the final packet of its word
word_count  output  CW  words currently held in FIFO
busy  output  1  FIFO non-empty

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO pointers, word_count and packet counter go to 0.
  - State goes to IDLE.
  - Outputs: out_valid=0, out_last=0, data_out=0, busy=0, word_count=0, in_ready=1.
- Input handshake:
  - Push when in_valid && in_ready.
  - Each FIFO entry stores {data_in, in_offset}.
  - in_ready = !full, combinational from registered state.
  - Pushes never depend on out_ready.
- Output handshake:
  - out_valid = !empty.
  - Packet index p = head.offset + cnt, where cnt is an OW-bit consumed-packet counter.
  - data_out = head.word[p*PACKET_WIDTH +: PACKET_WIDTH].
  - out_last = out_valid && (p == N-1).
  - data_out = 0 when empty.
- Latency: a word pushed at edge t is visible on out_valid/data_out after edge t (registered FIFO); no same-cycle bypass.
- State machine:
  - IDLE: FIFO empty. Goes to STREAM on push.
  - STREAM: out_valid=1. On a transfer (out_valid && out_ready): if !out_last, cnt <= cnt+1; else pop head and cnt <= 0.
  - From STREAM, go to IDLE when the final word pops and no push occurs in the same cycle.
- Offset rule: a word with in_offset=k emits N-k packets. in_offset=N-1 emits exactly one packet, which has out_last=1.
- Simultaneous push and pop: both take effect; word_count unchanged.
  - When full, in_ready=0, so no push occurs even if a pop happens that cycle. Pop frees the slot for the next cycle.
- Wrap-around: read/write pointers wrap modulo DEPTH. Full/empty are derived from word_count.
- Stall: with out_ready=0, data_out, out_last and cnt hold stable; out_valid stays asserted.
- Flush:
  - Takes effect at the next edge and overrides push and pop in that cycle. The in_valid word is dropped and must not be counted.
  - Clears pointers, word_count and cnt; returns to IDLE.
- Reset mid-word: any partially emitted word is discarded. No packet is emitted after rst deassertion until a new push.

Optional Feature:
- Macro WAVELET_SERIALIZER_MSB_FIRST_EN.
- Defined:
  - Packet slice index becomes N-1-p, so packets are emitted most-significant first.
  - in_offset counts from the MSB end.
  - out_last condition (p == N-1) is unchanged.
- Undefined: least-significant packet first, as specified above.

Test Plan:
- Push 0xDDCCBBAA, offset 0, out_ready=1 -> packets AA, BB, CC, DD on consecutive cycles; out_last only on DD; busy falls after DD.
- Push 0x44332211 offset 2, then 0x88776655 offset 3 -> packets 33, 44(last), 88(last); word_count sequence 1,2,1,0.
- Push 3 words with out_ready=0, DEPTH=2 -> in_ready=0 after 2 pushes; word_count=2; third word held upstream. Raise out_ready -> third word accepted the cycle after first pop; all 12 packets arrive in order.
- Full FIFO with simultaneous out_last transfer and in_valid -> no push that cycle; push accepted next cycle; no data lost.
- Assert flush while streaming mid-word with in_valid=1 -> next cycle out_valid=0, word_count=0, in_ready=1; the dropped word never appears.
- Assert rst low mid-word, release, push 0x0A0B0C0D -> first packet 0D; with WAVELET_SERIALIZER_MSB_FIRST_EN defined, first packet is 0A.
